mem_16x32_sync: RTL and testbench

- Single-port synchronous memory, 16 words x 32 bits; the memory DUT of the class-based verification environment.
- One operation per clock, selected by EN: EN=1 writes Data_In to Addr; EN=0 reads Addr.
- Read data is returned one cycle later on Data_Out, qualified by a one-cycle Valid_Out pulse.
- Connects to the environment interface through its memory-side port group (clk, rst, Data_In, Addr, EN as inputs; Data_Out, Valid_Out as outputs).

---
 rtl/mem_pkg.sv | 12 +
 rtl/mem_16x32_sync_if.sv | 28 ++
 rtl/mem_regfile.sv | 28 ++
 rtl/mem_16x32_sync.sv | 39 +++
 tb/tb_mem_16x32_sync.sv | 135 +++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared widths and word/address types for the 16x32 synchronous memory.
// Pure type/constant package: no logic, no latency.
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage : mem_pkg

// File: rtl/mem_16x32_sync_if.sv
// Memory-side signal group: one op per cycle (EN=1 write, EN=0 read).
// Read result returns 1 cycle later with a Valid_Out pulse; no backpressure.
interface mem_16x32_sync_if;
    import mem_pkg::*;

    word_t Data_In;
    addr_t Addr;
    logic  EN;
    word_t Data_Out;
    logic  Valid_Out;

    modport master (
        output Data_In,
        output Addr,
        output EN,
        input  Data_Out,
        input  Valid_Out
    );

    modport slave (
        input  Data_In,
        input  Addr,
        input  EN,
        output Data_Out,
        output Valid_Out
    );

endinterface : mem_16x32_sync_if

// File: rtl/mem_regfile.sv
// DEPTH x DATA_W storage: synchronous clear and write, combinational read.
// Write takes effect at the edge; read is 0-latency; no backpressure.
module mem_regfile
    import mem_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  we,
    input  addr_t addr,
    input  word_t wdata,
    output word_t rdata
);

    word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule : mem_regfile

// File: rtl/mem_16x32_sync.sv
// Single-port 16x32 memory: EN=1 writes, EN=0 reads with registered output.
// Read latency 1 clk, Valid_Out pulses per read; accepts an op every cycle.
module mem_16x32_sync
    import mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    mem_16x32_sync_if.slave    bus
);

    word_t rd_dat;
    logic  wr_en;

    // Reset blocks the write so X on EN/Addr/Data_In cannot disturb the array.
    assign wr_en = bus.EN && !rst;

    mem_regfile u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .addr  (bus.Addr),
        .wdata (bus.Data_In),
        .rdata (rd_dat)
    );

    // Data_Out only moves on a read or reset; writes leave it holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Data_Out  <= '0;
            bus.Valid_Out <= 1'b0;
        end else if (bus.EN) begin
            bus.Valid_Out <= 1'b0;
        end else begin
            bus.Data_Out  <= rd_dat;
            bus.Valid_Out <= 1'b1;
        end
    end

endmodule : mem_16x32_sync

// File: tb/tb_mem_16x32_sync.sv
// Directed and random checks of mem_16x32_sync against hand values and a reference array.
module tb_mem_16x32_sync;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;

    mem_16x32_sync_if bus ();

    mem_16x32_sync dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic op(input logic r, input logic e, input addr_t a, input word_t d);
        rst         = r;
        bus.EN      = e;
        bus.Addr    = a;
        bus.Data_In = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $display("FAIL %s: observed %b expected %b", tag, obs, exp);
            $error("%s observed %b expected %b", tag, obs, exp);
        end
    endtask

    word_t ref_mem [DEPTH];
    word_t exp_do;
    logic  exp_v;
    logic  r_rst, r_en;
    addr_t r_a;
    word_t r_d;

    initial begin
        // Reset with all inputs unknown
        op(1'b1, 1'bx, 'x, 'x);
        op(1'b1, 1'bx, 'x, 'x);
        check_word("reset_dout", bus.Data_Out, 32'h0);
        check_bit("reset_vld", bus.Valid_Out, 1'b0);

        // Every location reads zero after reset
        for (int i = 0; i < DEPTH; i++) begin
            op(1'b0, 1'b0, addr_t'(i), 'x);
            check_word("clear_rd_dout", bus.Data_Out, 32'h0);
            check_bit("clear_rd_vld", bus.Valid_Out, 1'b1);
        end

        // Write then read same address on the next cycle
        op(1'b0, 1'b1, 4'h3, 32'hDEADBEEF);
        check_bit("wr3_vld", bus.Valid_Out, 1'b0);
        check_word("wr3_hold", bus.Data_Out, 32'h0);
        op(1'b0, 1'b0, 4'h3, 'x);
        check_word("rd3_dout", bus.Data_Out, 32'hDEADBEEF);
        check_bit("rd3_vld", bus.Valid_Out, 1'b1);

        // Fill with 1000_0000+i, read back 15..0 back-to-back
        for (int i = 0; i < DEPTH; i++) begin
            op(1'b0, 1'b1, addr_t'(i), 32'h1000_0000 + word_t'(i));
        end
        check_bit("fill_vld", bus.Valid_Out, 1'b0);
        check_word("fill_hold", bus.Data_Out, 32'hDEADBEEF);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            op(1'b0, 1'b0, addr_t'(i), 'x);
            check_word("b2b_dout", bus.Data_Out, 32'h1000_0000 + word_t'(i));
            check_bit("b2b_vld", bus.Valid_Out, 1'b1);
        end

        // Last write wins; a following write leaves Data_Out alone
        op(1'b0, 1'b1, 4'h7, 32'hA5A5A5A5);
        op(1'b0, 1'b1, 4'h7, 32'h5A5A5A5A);
        op(1'b0, 1'b0, 4'h7, 'x);
        check_word("lww_dout", bus.Data_Out, 32'h5A5A5A5A);
        check_bit("lww_vld", bus.Valid_Out, 1'b1);
        op(1'b0, 1'b1, 4'h0, 32'h1000_0000);
        check_word("idle_hold", bus.Data_Out, 32'h5A5A5A5A);
        check_bit("idle_vld", bus.Valid_Out, 1'b0);

        // Reset mid-stream drops the concurrent read and clears contents
        op(1'b0, 1'b1, 4'h9, 32'hCAFEF00D);
        op(1'b1, 1'b0, 4'h9, 'x);
        check_bit("rstmid_vld", bus.Valid_Out, 1'b0);
        check_word("rstmid_dout", bus.Data_Out, 32'h0);
        op(1'b0, 1'b0, 4'h9, 'x);
        check_word("rstmid_rd9", bus.Data_Out, 32'h0);
        check_bit("rstmid_rd9_vld", bus.Valid_Out, 1'b1);
        op(1'b0, 1'b0, 4'h7, 'x);
        check_word("rstmid_rd7", bus.Data_Out, 32'h0);

        // Random mix against a reference array
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_do = '0;
        for (int c = 0; c < 1000; c++) begin
            r_rst = ($urandom_range(0, 49) == 0);
            r_en  = 1'($urandom_range(0, 1));
            r_a   = addr_t'($urandom_range(0, DEPTH - 1));
            r_d   = word_t'($urandom);
            op(r_rst, r_en, r_a, r_d);
            if (r_rst) begin
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
                exp_do = '0;
            end else if (r_en) begin
                ref_mem[r_a] = r_d;
            end else begin
                exp_do = ref_mem[r_a];
            end
            exp_v = !r_en && !r_rst;
            check_bit("rand_vld", bus.Valid_Out, exp_v);
            check_word("rand_dout", bus.Data_Out, exp_do);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_mem_16x32_sync
